inst_mem: RTL and testbench
===========================

INST_MEM -- requirements
Module: inst_mem

Interface
REQ-001 Parameter DEPTH_LOG2, default 10, log2 of memory depth in 32-bit words (1024 words).
REQ-002 Parameter WAIT_CYCLES, default 0, extra response wait states, legal range 0..15.
REQ-003 clk  input  1  sole clock; all state updates on posedge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 ce  input  1  fetch request/chip enable from the fetch initiator; high = fetch requested.
REQ-006 addr  input  32  byte address of the requested instruction.
REQ-007 ld_en  input  1  load-port write enable (program preload).
REQ-008 ld_addr  input  DEPTH_LOG2  load-port word index.
REQ-009 ld_data  input  32  load-port write data.
REQ-010 inst  output  32  fetched instruction, registered.
REQ-011 inst_valid  output  1  one-cycle pulse; inst/err valid this cycle.
REQ-012 err  output  1  fetch fault flag, qualified by inst_valid.
REQ-013 stall  output  1  high while a fetch is in wait states; initiator holds addr and ce.

Function
REQ-014 Storage: 2^DEPTH_LOG2 x 32-bit words; word index = addr[DEPTH_LOG2+1:2].
REQ-015 FSM states IDLE and BUSY only; stall = (state == BUSY).
REQ-016 Accept: ce sampled high at a posedge while in IDLE; addr, misalign flag and range flag are captured at that edge.
REQ-017 WAIT_CYCLES == 0: the accepting edge itself loads inst and pulses inst_valid; FSM stays IDLE; back-to-back accepts every cycle are supported (one response per cycle).
REQ-018 WAIT_CYCLES == N > 0: accepting edge moves IDLE->BUSY and loads a 4-bit counter with N; inst_valid stays low.
REQ-019 BUSY: counter decrements each posedge; at the edge where counter == 1, inst/err are loaded, inst_valid pulses, FSM returns to IDLE.
REQ-020 Latency: inst_valid is high in the cycle following the (N+1)-th posedge counted from, and including, the accepting edge.
REQ-021 After a BUSY->IDLE return, a new accept is possible at the very next posedge if ce is high.
REQ-022 Abort: ce sampled low in BUSY returns FSM to IDLE at that edge with no inst_valid pulse; the counter is cleared.
REQ-023 Misaligned: addr[1:0] != 0 -> response with err=1, inst=0.
REQ-024 Out of range: addr[31:DEPTH_LOG2+2] != 0 -> response with err=1, inst=0; misaligned and out-of-range together give a single err response.
REQ-025 Good fetch: err=0, inst = stored word.
REQ-026 inst and err are 0 in every cycle where inst_valid is 0.
REQ-027 Load port: ld_en high at posedge writes ld_data to word ld_addr; operates in any FSM state, independent of ce.
REQ-028 Same-edge collision (ld_en write and response load to the same word): response returns the old word; the write takes effect for later fetches.
REQ-029 ce low in IDLE: no response; outputs remain 0.

Reset
REQ-030 rst high immediately forces FSM to IDLE, counter to 0, inst to 0, inst_valid to 0, err to 0, stall to 0, independent of clk.
REQ-031 Reset mid-fetch discards the pending fetch with no response after reset release.
REQ-032 Memory contents are not altered by reset; words loaded before reset are fetchable after it.
REQ-033 First accept is possible at the first posedge with rst low and ce high.

Verification
REQ-034 WAIT_CYCLES=0; preload words 0..3 = 0x11111111..0x44444444; ce=1 with addr 0x0,0x4,0x8,0xC on consecutive cycles -> inst_valid high four consecutive cycles, inst = 0x11111111,0x22222222,0x33333333,0x44444444.
REQ-035 WAIT_CYCLES=3; fetch addr 0x4 -> stall high for 3 cycles, inst_valid pulses exactly once in the cycle after the 4th edge, inst=0x22222222, err=0.
REQ-036 addr 0x6, then addr 0x00001000 (DEPTH_LOG2=10) -> each gives inst_valid=1, err=1, inst=0x00000000.
REQ-037 WAIT_CYCLES=3; ce drops after 1 wait cycle -> FSM IDLE, no inst_valid pulse; next accept completes normally.
REQ-038 WAIT_CYCLES=2; assert rst asynchronously mid-BUSY -> all outputs 0 before the next posedge; after release, fetch of addr 0x0 returns 0x11111111.
REQ-039 Same-edge ld_en write of 0xDEADBEEF to word 1 while fetching addr 0x4 -> returns 0x22222222; refetch returns 0xDEADBEEF.

Source files
------------

// File: rtl/inst_mem_if.sv
// rtl/inst_mem_if.sv - fetch and program-load port bundle for inst_mem
interface inst_mem_if #(
  parameter int DEPTH_LOG2 = 10
);
  logic                  ce;
  logic [31:0]           addr;
  logic                  ld_en;
  logic [DEPTH_LOG2-1:0] ld_addr;
  logic [31:0]           ld_data;
  logic [31:0]           inst;
  logic                  inst_valid;
  logic                  err;
  logic                  stall;

  modport master (
    output ce, addr, ld_en, ld_addr, ld_data,
    input  inst, inst_valid, err, stall
  );

  modport slave (
    input  ce, addr, ld_en, ld_addr, ld_data,
    output inst, inst_valid, err, stall
  );
endinterface

// File: rtl/inst_mem.sv
// rtl/inst_mem.sv - instruction memory with optional response wait states and a preload port
module inst_mem #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 0
) (
  input logic       clk,
  input logic       rst,
  inst_mem_if.slave bus
);
  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d, rd_idx;
  logic                  bad_q, bad_d;
  logic                  resp, resp_bad, req_bad;
  logic [31:0]           inst_q;
  logic                  valid_q, err_q;

  logic [31:0] mem [2**DEPTH_LOG2];

  assign req_bad = (bus.addr[1:0] != 2'b00) || (bus.addr[31:DEPTH_LOG2+2] != '0);

  // Load port is deliberately outside reset so preloaded programs survive it.
  always_ff @(posedge clk) begin
    if (bus.ld_en) mem[bus.ld_addr] <= bus.ld_data;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    bad_d    = bad_q;
    resp     = 1'b0;
    rd_idx   = idx_q;
    resp_bad = bad_q;
    case (state_q)
      IDLE: begin
        if (bus.ce) begin
          idx_d = bus.addr[DEPTH_LOG2+1:2];
          bad_d = req_bad;
          if (WAIT_CYCLES == 0) begin
            resp     = 1'b1;
            rd_idx   = bus.addr[DEPTH_LOG2+1:2];
            resp_bad = req_bad;
          end else begin
            state_d = BUSY;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      BUSY: begin
        if (!bus.ce) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd1) begin
          resp    = 1'b1;
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // mem is read here with pre-edge contents, so a same-edge load returns the old word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      bad_q   <= 1'b0;
      inst_q  <= 32'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      bad_q   <= bad_d;
      valid_q <= resp;
      err_q   <= resp && resp_bad;
      inst_q  <= (resp && !resp_bad) ? mem[rd_idx] : 32'd0;
    end
  end

  assign bus.inst       = inst_q;
  assign bus.inst_valid = valid_q;
  assign bus.err        = err_q;
  assign bus.stall      = (state_q == BUSY);
endmodule

// File: tb/tb_inst_mem.sv
// tb/tb_inst_mem.sv - randomized self-checking bench for inst_mem at 0, 2 and 3 wait states
module tb_inst_mem;
  localparam int DL = 10;

  logic clk;
  logic rst;

  logic          ce_d      [3];
  logic [31:0]   addr_d    [3];
  logic          ld_en_d   [3];
  logic [DL-1:0] ld_addr_d [3];
  logic [31:0]   ld_data_d [3];
  logic [31:0]   inst_o    [3];
  logic          valid_o   [3];
  logic          err_o     [3];
  logic          stall_o   [3];

  logic [31:0] model [3][2**DL];

  int checks;
  int failures;

  inst_mem_if #(.DEPTH_LOG2(DL)) bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign bus[g].ce      = ce_d[g];
    assign bus[g].addr    = addr_d[g];
    assign bus[g].ld_en   = ld_en_d[g];
    assign bus[g].ld_addr = ld_addr_d[g];
    assign bus[g].ld_data = ld_data_d[g];
    assign inst_o[g]      = bus[g].inst;
    assign valid_o[g]     = bus[g].inst_valid;
    assign err_o[g]       = bus[g].err;
    assign stall_o[g]     = bus[g].stall;

    inst_mem #(
      .DEPTH_LOG2 (DL),
      .WAIT_CYCLES(g == 0 ? 0 : (g == 1 ? 2 : 3))
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus[g].slave)
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int wait_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
  endfunction

  // {err, inst} the memory owes for a fetch of byte address a
  function automatic logic [32:0] expect_resp(input int k, input logic [31:0] a);
    if ((a % 4) != 0 || a >= (32'd4 << DL)) return {1'b1, 32'd0};
    return {1'b0, model[k][a / 4]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int k);
    @(posedge clk);
    if (ld_en_d[k]) model[k][ld_addr_d[k]] = ld_data_d[k];
    @(negedge clk);
    ld_en_d[k] = 1'b0;
  endtask

  task automatic idle(input int k, input int n);
    ce_d[k] = 1'b0;
    for (int i = 0; i < n; i++) begin
      step(k);
      check($sformatf("idle_valid%0d", k), valid_o[k], 0);
      check($sformatf("idle_inst%0d", k), inst_o[k], 0);
      check($sformatf("idle_err%0d", k), err_o[k], 0);
      check($sformatf("idle_stall%0d", k), stall_o[k], 0);
    end
  endtask

  // Holds ce through the whole fetch and leaves it high, so calls chain back to back.
  task automatic do_fetch(input int k, input logic [31:0] a, input bit rnd);
    int n;
    logic [32:0] e;
    n = wait_of(k);
    e = '0;
    ce_d[k]   = 1'b1;
    addr_d[k] = a;
    for (int i = 0; i <= n; i++) begin
      if (rnd && $urandom_range(0, 1) == 1) begin
        ld_en_d[k]   = 1'b1;
        ld_addr_d[k] = DL'($urandom_range(0, 15));
        ld_data_d[k] = $urandom;
      end
      if (i == n) e = expect_resp(k, a);
      step(k);
      if (i < n) begin
        check($sformatf("wait_stall%0d", k), stall_o[k], 1);
        check($sformatf("wait_valid%0d", k), valid_o[k], 0);
        check($sformatf("wait_inst%0d", k), inst_o[k], 0);
      end else begin
        check($sformatf("valid%0d a=%h", k, a), valid_o[k], 1);
        check($sformatf("stall%0d a=%h", k, a), stall_o[k], 0);
        check($sformatf("inst%0d a=%h", k, a), inst_o[k], e[31:0]);
        check($sformatf("err%0d a=%h", k, a), err_o[k], {31'd0, e[32]});
      end
    end
  endtask

  initial begin
    logic [31:0] a;
    int r;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ce_d[k] = 1'b0; addr_d[k] = '0; ld_en_d[k] = 1'b0; ld_addr_d[k] = '0; ld_data_d[k] = '0;
    end
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_valid%0d", k), valid_o[k], 0);
      check($sformatf("rst_inst%0d", k), inst_o[k], 0);
      check($sformatf("rst_err%0d", k), err_o[k], 0);
      check($sformatf("rst_stall%0d", k), stall_o[k], 0);
    end
    rst = 1'b0;

    // preload: words 0..3 fixed pattern, 4..15 random, on every instance
    for (int w = 0; w < 16; w++) begin
      for (int k = 0; k < 3; k++) begin
        ld_en_d[k]   = 1'b1;
        ld_addr_d[k] = DL'(w);
        ld_data_d[k] = (w < 4) ? 32'h11111111 * (w + 1) : $urandom;
      end
      @(posedge clk);
      for (int k = 0; k < 3; k++) model[k][w] = ld_data_d[k];
      @(negedge clk);
      for (int k = 0; k < 3; k++) ld_en_d[k] = 1'b0;
    end

    // zero-wait back-to-back stream
    for (int i = 0; i < 4; i++) do_fetch(0, 32'(i * 4), 1'b0);
    check("b2b_last", inst_o[0], 32'h44444444);
    idle(0, 2);

    do_fetch(0, 32'h6, 1'b0);
    do_fetch(0, 32'h1000, 1'b0);
    idle(0, 1);

    // same-edge load to the fetched word returns the old word
    ld_en_d[0] = 1'b1; ld_addr_d[0] = DL'(1); ld_data_d[0] = 32'hDEADBEEF;
    do_fetch(0, 32'h4, 1'b0);
    check("collide_old", inst_o[0], 32'h22222222);
    do_fetch(0, 32'h4, 1'b0);
    check("collide_new", inst_o[0], 32'hDEADBEEF);
    idle(0, 1);

    do_fetch(2, 32'h4, 1'b0);
    check("w3_inst", inst_o[2], 32'h22222222);
    idle(2, 3);
    do_fetch(2, 32'h6, 1'b0);
    do_fetch(2, 32'h1000, 1'b0);
    idle(2, 1);

    // abort after one wait cycle
    ce_d[2] = 1'b1; addr_d[2] = 32'h8;
    step(2);
    check("abort_busy", stall_o[2], 1);
    ce_d[2] = 1'b0;
    step(2);
    check("abort_stall", stall_o[2], 0);
    check("abort_valid", valid_o[2], 0);
    idle(2, 4);
    do_fetch(2, 32'h8, 1'b0);
    check("abort_next", inst_o[2], 32'h33333333);
    idle(2, 1);

    // asynchronous reset while BUSY
    ce_d[1] = 1'b1; addr_d[1] = 32'h0;
    step(1);
    check("rst_pre_stall", stall_o[1], 1);
    #2 rst = 1'b1;
    #1;
    check("arst_stall", stall_o[1], 0);
    check("arst_valid", valid_o[1], 0);
    check("arst_inst", inst_o[1], 0);
    check("arst_err", err_o[1], 0);
    @(negedge clk);
    ce_d[1] = 1'b0;
    rst     = 1'b0;
    idle(1, 4);
    do_fetch(1, 32'h0, 1'b0);
    check("post_rst_inst", inst_o[1], 32'h11111111);
    idle(1, 1);

    // randomized fetches with concurrent preload traffic
    for (int k = 0; k < 3; k++) begin
      for (int t = 0; t < 25; t++) begin
        r = $urandom_range(0, 9);
        if (r == 0)      a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
        else if (r == 1) a = $urandom | 32'h1000;
        else             a = 32'($urandom_range(0, 15) * 4);
        do_fetch(k, a, 1'b1);
        if ($urandom_range(0, 3) == 0) idle(k, 1);
      end
      idle(k, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
